// File: rtl/uart_reg_mem_bank.sv
// Register/memory bank on the UART command bus: NREG control registers with
// bit-set/clear/toggle, a read-only switch port, a block memory with a fill engine.
module uart_reg_mem_bank #(
    parameter logic [15:0] BASE_ADR = 16'h0100,
    parameter int          NREG     = 4,
    parameter int          MEM_AW   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_wr_dat,
    input  logic [7:0]  rx_dat,
    input  logic [7:0]  com,
    input  logic [15:0] wr_adr,
    input  logic [15:0] rd_adr,
    input  logic [7:0]  SW,
    output logic [7:0]  LED,
    output logic [15:0] DISPL,
    output logic        busy,
    output logic [7:0]  my_dat
);

    localparam int          DEPTH   = 1 << MEM_AW;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [15:0] NREG_W  = 16'(NREG);

    localparam logic [7:0] CMD_REG_WR  = 8'h00;
    localparam logic [7:0] CMD_MEM_WR  = 8'h01;
    localparam logic [7:0] CMD_REG_SET = 8'h02;
    localparam logic [7:0] CMD_REG_CLR = 8'h03;
    localparam logic [7:0] CMD_REG_TGL = 8'h04;
    localparam logic [7:0] CMD_FILL    = 8'h05;
    localparam logic [7:0] CMD_RD_REG  = 8'h80;
    localparam logic [7:0] CMD_RD_MEM  = 8'h81;
    localparam logic [7:0] CMD_RD_STAT = 8'h82;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } fill_state_e;

    fill_state_e              state_q, state_d;
    logic [MEM_AW-1:0]        ptr_q, ptr_d;
    logic [7:0]               fill_val_q, fill_val_d;
    logic [NREG-1:0][7:0]     regs_q, regs_d;
    logic [7:0]               reg_rd_q, reg_rd_d;
    logic [7:0]               mem_rd_q;
    logic [7:0]               mem [DEPTH];

    logic                     mem_we;
    logic [MEM_AW-1:0]        mem_wa;
    logic [7:0]               mem_wd;

    // Offsets below the base would wrap, so the lower bound is checked explicitly.
    logic [15:0] wr_off, rd_off;
    logic        wr_in_base, rd_in_base;
    logic        wr_reg_hit, wr_mem_hit, rd_mem_hit;

    assign wr_in_base = (wr_adr >= BASE_ADR);
    assign rd_in_base = (rd_adr >= BASE_ADR);
    assign wr_off     = wr_adr - BASE_ADR;
    assign rd_off     = rd_adr - BASE_ADR;
    assign wr_reg_hit = wr_in_base && (wr_off < NREG_W);
    assign wr_mem_hit = wr_in_base && ({1'b0, wr_off} < DEPTH_W);
    assign rd_mem_hit = rd_in_base && ({1'b0, rd_off} < DEPTH_W);

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        regs_d = regs_q;
        if (ce_wr_dat && wr_reg_hit) begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_off == 16'(i)) begin
                    case (com)
                        CMD_REG_WR:  regs_d[i] = rx_dat;
                        CMD_REG_SET: regs_d[i] = regs_q[i] | rx_dat;
                        CMD_REG_CLR: regs_d[i] = regs_q[i] & ~rx_dat;
                        CMD_REG_TGL: regs_d[i] = regs_q[i] ^ rx_dat;
                        default:     ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        reg_rd_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_in_base && (rd_off == 16'(i))) begin
                reg_rd_d = regs_q[i];
            end
        end
        if (rd_in_base && (rd_off == NREG_W)) begin
            reg_rd_d = SW;
        end
    end

    // Single memory write port: the fill engine owns it while busy, 0x01 otherwise.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fill_val_d = fill_val_q;
        mem_we     = 1'b0;
        mem_wa     = ptr_q;
        mem_wd     = fill_val_q;
        case (state_q)
            S_IDLE: begin
                if (ce_wr_dat && wr_mem_hit && (com == CMD_FILL)) begin
                    state_d    = S_FILL;
                    ptr_d      = wr_off[MEM_AW-1:0];
                    fill_val_d = rx_dat;
                end else if (ce_wr_dat && wr_mem_hit && (com == CMD_MEM_WR)) begin
                    mem_we = 1'b1;
                    mem_wa = wr_off[MEM_AW-1:0];
                    mem_wd = rx_dat;
                end
            end
            S_FILL: begin
                mem_we = 1'b1;
                if (ptr_q == '1) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            fill_val_q <= '0;
            regs_q     <= '0;
            reg_rd_q   <= '0;
            mem_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fill_val_q <= fill_val_d;
            regs_q     <= regs_d;
            reg_rd_q   <= reg_rd_d;
            mem_rd_q   <= rd_mem_hit ? mem[rd_off[MEM_AW-1:0]] : '0;
        end
    end

    // NOTE: the memory array has no reset so it maps onto block RAM; contents
    // survive a reset, only the read register is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign LED   = regs_q[0];
    assign DISPL = {regs_q[1], regs_q[2]};
    assign busy  = (state_q == S_FILL);

    always_comb begin
        case (com)
            CMD_RD_REG:  my_dat = reg_rd_q;
            CMD_RD_MEM:  my_dat = mem_rd_q;
            CMD_RD_STAT: my_dat = {7'b0, busy};
            default:     my_dat = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_reg_mem_bank.sv
// Self-checking bench for uart_reg_mem_bank: directed plan steps plus random
// register/memory traffic scored against a behavioural array model.
module tb_uart_reg_mem_bank;

    localparam logic [15:0] BASE   = 16'h0100;
    localparam int          NREG   = 4;
    localparam int          MEM_AW = 8;
    localparam int          DEPTH  = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_wr_dat;
    logic [7:0]  rx_dat;
    logic [7:0]  com;
    logic [15:0] wr_adr;
    logic [15:0] rd_adr;
    logic [7:0]  SW;
    logic [7:0]  LED;
    logic [15:0] DISPL;
    logic        busy;
    logic [7:0]  my_dat;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] regs_m [NREG];
    logic [7:0] mem_m  [DEPTH];
    bit         known_m[DEPTH];
    logic [7:0] sw_m;
    logic [7:0] cmd_tab [6] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h01, 8'h07};

    always #5 clk = ~clk;

    uart_reg_mem_bank #(
        .BASE_ADR (BASE),
        .NREG     (NREG),
        .MEM_AW   (MEM_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_wr_dat (ce_wr_dat),
        .rx_dat    (rx_dat),
        .com       (com),
        .wr_adr    (wr_adr),
        .rd_adr    (rd_adr),
        .SW        (SW),
        .LED       (LED),
        .DISPL     (DISPL),
        .busy      (busy),
        .my_dat    (my_dat)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [7:0] cmd, input logic [15:0] adr, input logic [7:0] dat);
        int off;
        off = int'(adr) - int'(BASE);
        if (off >= 0 && off < NREG) begin
            case (cmd)
                8'h00:   regs_m[off] = dat;
                8'h02:   regs_m[off] = regs_m[off] | dat;
                8'h03:   regs_m[off] = regs_m[off] & ~dat;
                8'h04:   regs_m[off] = regs_m[off] ^ dat;
                default: ;
            endcase
        end
        if (cmd == 8'h01 && off >= 0 && off < DEPTH) begin
            mem_m[off]   = dat;
            known_m[off] = 1'b1;
        end
    endtask

    function automatic logic [7:0] exp_reg(input logic [15:0] adr);
        int off;
        off = int'(adr) - int'(BASE);
        if (off >= 0 && off < NREG) return regs_m[off];
        if (off == NREG) return sw_m;
        return 8'h00;
    endfunction

    task automatic wr(input logic [7:0] cmd, input logic [15:0] adr, input logic [7:0] dat);
        ce_wr_dat = 1'b1;
        com       = cmd;
        wr_adr    = adr;
        rx_dat    = dat;
        step();
        ce_wr_dat = 1'b0;
        com       = 8'hFF;
        model_write(cmd, adr, dat);
    endtask

    task automatic rd_reg(input logic [15:0] adr, input string tag);
        rd_adr = adr;
        com    = 8'h80;
        step();
        check(tag, {8'h00, my_dat}, {8'h00, exp_reg(adr)});
    endtask

    task automatic rd_mem(input logic [15:0] adr, input string tag);
        int off;
        off    = int'(adr) - int'(BASE);
        rd_adr = adr;
        com    = 8'h81;
        step();
        if (off < 0 || off >= DEPTH) begin
            check(tag, {8'h00, my_dat}, 16'h0000);
        end else if (known_m[off]) begin
            check(tag, {8'h00, my_dat}, {8'h00, mem_m[off]});
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_led"}, {8'h00, LED}, {8'h00, regs_m[0]});
        check({tag, "_displ"}, DISPL, {regs_m[1], regs_m[2]});
    endtask

    task automatic fill_model(input int m, input logic [7:0] val);
        for (int i = m; i < DEPTH; i++) begin
            mem_m[i]   = val;
            known_m[i] = 1'b1;
        end
    endtask

    task automatic start_fill(input logic [15:0] adr, input logic [7:0] val);
        ce_wr_dat = 1'b1;
        com       = 8'h05;
        wr_adr    = adr;
        rx_dat    = val;
        step();
        ce_wr_dat = 1'b0;
        com       = 8'h82;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [7:0]  cmd;
        logic [15:0] adr;
        logic [7:0]  dat;

        ce_wr_dat = 1'b0;
        rx_dat    = 8'h00;
        com       = 8'h80;
        wr_adr    = 16'h0000;
        rd_adr    = BASE;
        SW        = 8'h00;
        sw_m      = 8'h00;
        rst_n     = 1'b0;
        for (int i = 0; i < NREG; i++) regs_m[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

        step();
        step();
        check("rst_my_dat", {8'h00, my_dat}, 16'h0000);
        rst_n = 1'b1;
        check("rst_led", {8'h00, LED}, 16'h0000);
        check("rst_displ", DISPL, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        for (int i = 0; i < 4; i++) rd_reg(BASE + 16'(i), "rst_rd_reg");

        wr(8'h00, BASE, 8'hA5);
        check("led_write", {8'h00, LED}, 16'h00A5);
        wr(8'h02, BASE, 8'h0F);
        check("led_set", {8'h00, LED}, 16'h00AF);
        wr(8'h03, BASE, 8'h81);
        check("led_clear", {8'h00, LED}, 16'h002E);
        wr(8'h04, BASE, 8'hFF);
        check("led_toggle", {8'h00, LED}, 16'h00D1);
        wr(8'h00, BASE + 16'd1, 8'h12);
        wr(8'h00, BASE + 16'd2, 8'h34);
        check("displ", DISPL, 16'h1234);

        SW   = 8'h5A;
        sw_m = 8'h5A;
        wr(8'h00, BASE + 16'(NREG), 8'hFF);
        check_outputs("sw_write_ignored");
        rd_reg(BASE + 16'(NREG), "sw_read");
        check("sw_read_const", {8'h00, my_dat}, 16'h005A);
        rd_reg(BASE - 16'd1, "reg_below_window");

        wr(8'h01, BASE + 16'h10, 8'h3C);
        rd_mem(BASE + 16'h10, "mem_rd");
        check("mem_rd_const", {8'h00, my_dat}, 16'h003C);
        rd_mem(BASE + 16'h100, "mem_out_of_window");

        for (int n = 0; n < 60; n++) begin
            cmd = cmd_tab[$urandom_range(0, 5)];
            dat = 8'($urandom);
            if ($urandom_range(0, 7) == 0) adr = 16'($urandom);
            else if (cmd == 8'h01) adr = BASE + 16'($urandom_range(0, DEPTH + 3));
            else adr = BASE + 16'($urandom_range(0, NREG + 1));
            wr(cmd, adr, dat);
            check_outputs("rand");
            rd_reg(BASE + 16'($urandom_range(0, NREG + 1)), "rand_rd_reg");
            if (cmd == 8'h01) rd_mem(adr, "rand_rd_mem");
        end

        wr(8'h01, BASE + 16'hEF, 8'h5D);
        wr(8'h01, BASE + 16'h20, 8'h11);
        start_fill(BASE + 16'hF0, 8'hEE);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            ce_wr_dat = 1'b0;
            com       = 8'h82;
            if (cnt == 3) begin
                ce_wr_dat = 1'b1; com = 8'h01; wr_adr = BASE + 16'h20; rx_dat = 8'h99;
            end
            if (cnt == 5) begin
                ce_wr_dat = 1'b1; com = 8'h00; wr_adr = BASE; rx_dat = 8'h42;
                regs_m[0] = 8'h42;
            end
            if (cnt == 7) begin
                ce_wr_dat = 1'b1; com = 8'h05; wr_adr = BASE; rx_dat = 8'h55;
            end
            @(negedge clk);
            if (cnt == 8) check("busy_rd_fill", {8'h00, my_dat}, 16'h0001);
            step();
            cnt++;
        end
        ce_wr_dat = 1'b0;
        com       = 8'h82;
        check("fill_busy_cycles", 16'(cnt), 16'd16);
        check("led_mid_fill", {8'h00, LED}, 16'h0042);
        @(negedge clk);
        check("busy_rd_idle", {8'h00, my_dat}, 16'h0000);
        fill_model(16'hF0, 8'hEE);
        for (int i = 16'hE8; i < DEPTH; i++) rd_mem(BASE + 16'(i), "fill_mem");
        rd_mem(BASE + 16'hEF, "fill_below");
        check("fill_below_const", {8'h00, my_dat}, 16'h005D);
        rd_mem(BASE + 16'h20, "memwr_dropped");
        check("memwr_dropped_const", {8'h00, my_dat}, 16'h0011);

        start_fill(BASE + 16'hFF, 8'h3A);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            step();
            cnt++;
        end
        check("fill_last_busy", 16'(cnt), 16'd1);
        fill_model(16'hFF, 8'h3A);
        rd_mem(BASE + 16'hFF, "fill_last_mem");

        wr(8'h01, BASE + 16'h05, 8'h66);
        start_fill(BASE, 8'h77);
        check("abort_busy_start", {15'h0, busy}, 16'h0001);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", {15'h0, busy}, 16'h0000);
        for (int i = 0; i < NREG; i++) regs_m[i] = 8'h00;
        check_outputs("abort_regs");
        for (int i = 0; i < 5; i++) begin
            mem_m[i]   = 8'h77;
            known_m[i] = 1'b1;
        end
        for (int i = 0; i < 6; i++) rd_mem(BASE + 16'(i), "abort_mem");
        check("abort_mem5_const", {8'h00, my_dat}, 16'h0066);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
